// File: rtl/ro_bus_capture_pkg.sv
// ---------------------------------------------------------------------------
// ro_pkg
// Shared definitions for the readout bus capture slice.
//   N_CH_DEF  : default number of cores / slot counter width
//   CH_W_DEF  : default core index width
//   ro_evt_t  : packed event record {ts, ch, pol} at the default widths
//   ro_ctz    : trailing-zero count used to decode the bus owner from the
//               binary slot count (the toggling gray bit is bit ctz(count))
// ---------------------------------------------------------------------------
package ro_pkg;

  localparam int N_CH_DEF = 19;
  localparam int CH_W_DEF = 5;

  typedef struct packed {
    logic [N_CH_DEF-1:0] ts;
    logic [CH_W_DEF-1:0] ch;
    logic                pol;
  } ro_evt_t;

  // Scanning from the top down leaves the index of the lowest set bit.
  // A zero input returns 0; callers treat count 0 as an idle slot anyway.
  function automatic logic [5:0] ro_ctz(input logic [31:0] v);
    logic [5:0] r;
    r = 6'd0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/ro_bus_capture_if.sv
// ---------------------------------------------------------------------------
// ro_bus_capture_if
// Valid/ready record stream from the capture block to the off-chip link.
//   out_valid : head record present
//   out_ready : consumer accepts the head record
//   out_ts    : slot count at capture
//   out_ch    : owning core index
//   out_pol   : sampled polarity
// master modport = capture block, slave modport = link / consumer.
// ---------------------------------------------------------------------------
interface ro_bus_capture_if #(
  parameter int N_CH = ro_pkg::N_CH_DEF,
  parameter int CH_W = ro_pkg::CH_W_DEF
);

  logic            out_valid;
  logic            out_ready;
  logic [N_CH-1:0] out_ts;
  logic [CH_W-1:0] out_ch;
  logic            out_pol;

  modport master (
    output out_valid,
    output out_ts,
    output out_ch,
    output out_pol,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_ts,
    input  out_ch,
    input  out_pol,
    output out_ready
  );

endinterface

// File: rtl/ro_bus_capture_evt_fifo.sv
// ---------------------------------------------------------------------------
// ro_evt_fifo
// Synchronous show-ahead FIFO holding captured event records.
//   clk_master, rstb : clock, asynchronous active-low reset
//   push, push_data  : write request and record
//   full             : no free entry
//   pop              : consumer takes the head this cycle
//   valid, head      : head record present / head record (zero when empty)
// A push while full is accepted only if a pop frees the head slot in the
// same cycle; the write then lands in the slot being vacated.
// ---------------------------------------------------------------------------
module ro_evt_fifo
  import ro_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type evt_t = ro_evt_t
) (
  input  logic clk_master,
  input  logic rstb,
  input  logic push,
  input  evt_t push_data,
  output logic full,
  input  logic pop,
  output logic valid,
  output evt_t head
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  evt_t        mem_q [DEPTH];
  logic        empty;
  logic        wr_en;
  logic        rd_en;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    valid    = !empty;
    rd_en    = pop && !empty;
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    // Outputs read as zero when empty so reset shows an all-zero record.
    head = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible behind valid.
  always_ff @(posedge clk_master) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ro_bus_capture.sv
// ---------------------------------------------------------------------------
// ro_bus_capture
// Captures events from the shared tri-state readout bus, tags them with the
// owning core and the slot count, and queues them for the off-chip link.
//   clk_master  : master clock shared with the gray counter and readout cells
//   rstb        : asynchronous active-low reset
//   bus_eve     : shared event line
//   bus_pol_eve : shared polarity line
//   en          : capture enable (low discards samples)
//   ovf_clr     : synchronous clear of ovf
//   ovf         : sticky, set when a record was dropped on a full FIFO
//   out_if      : valid/ready record stream (master side)
// ---------------------------------------------------------------------------
module ro_bus_capture
  import ro_pkg::*;
#(
  parameter int N_CH  = N_CH_DEF,
  parameter int DEPTH = 4,
  parameter int CH_W  = CH_W_DEF
) (
  input  logic                 clk_master,
  input  logic                 rstb,
  input  logic                 bus_eve,
  input  logic                 bus_pol_eve,
  input  logic                 en,
  input  logic                 ovf_clr,
  output logic                 ovf,
  ro_bus_capture_if.master     out_if
);

  typedef struct packed {
    logic [N_CH-1:0] ts;
    logic [CH_W-1:0] ch;
    logic            pol;
  } evt_t;

  logic [N_CH-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0] slot_ch;
  logic            smp_eve_q, smp_eve_d;
  logic            smp_pol_q, smp_pol_d;
  logic [N_CH-1:0] smp_cnt_q, smp_cnt_d;
  logic [CH_W-1:0] smp_ch_q, smp_ch_d;
  logic            ovf_q, ovf_d;
  logic            push;
  logic            drop;
  logic            fifo_full;
  logic            fifo_pop;
  logic            fifo_valid;
  evt_t            rec;
  evt_t            head;

  // The slot counter mirrors the gray counter, so the owning core of the
  // current high phase is the bit that toggled into this count.
  // Bus lines are compared against a hard 1 so float/X reads as no event.
  always_comb begin
    cnt_d     = cnt_q + 1'b1;
    slot_ch   = CH_W'(ro_ctz(32'(cnt_q)));
    smp_eve_d = (bus_eve === 1'b1);
    smp_pol_d = (bus_pol_eve === 1'b1);
    smp_cnt_d = cnt_q;
    smp_ch_d  = slot_ch;
  end

  // Push the record sampled at the previous falling edge; count 0 is the
  // idle slot with no owner. A full FIFO drops unless it pops this cycle,
  // and a drop overrides a simultaneous clear.
  always_comb begin
    push     = smp_eve_q && en && (smp_cnt_q != '0);
    fifo_pop = fifo_valid && out_if.out_ready;
    drop     = push && fifo_full && !fifo_pop;
    rec      = '{ts: smp_cnt_q, ch: smp_ch_q, pol: smp_pol_q};
    ovf_d    = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // The bus is only driven during the high phase, so it is sampled at the
  // end of that phase on the falling edge.
  always_ff @(negedge clk_master or negedge rstb) begin
    if (!rstb) begin
      smp_eve_q <= 1'b0;
      smp_pol_q <= 1'b0;
      smp_cnt_q <= '0;
      smp_ch_q  <= '0;
    end else begin
      smp_eve_q <= smp_eve_d;
      smp_pol_q <= smp_pol_d;
      smp_cnt_q <= smp_cnt_d;
      smp_ch_q  <= smp_ch_d;
    end
  end

  ro_evt_fifo #(
    .DEPTH (DEPTH),
    .evt_t (evt_t)
  ) u_fifo (
    .clk_master (clk_master),
    .rstb       (rstb),
    .push       (push),
    .push_data  (rec),
    .full       (fifo_full),
    .pop        (fifo_pop),
    .valid      (fifo_valid),
    .head       (head)
  );

  assign out_if.out_valid = fifo_valid;
  assign out_if.out_ts    = head.ts;
  assign out_if.out_ch    = head.ch;
  assign out_if.out_pol   = head.pol;
  assign ovf              = ovf_q;

endmodule

// File: tb/tb_ro_bus_capture.sv
// ---------------------------------------------------------------------------
// tb_ro_bus_capture
// Drives two capture instances (19-core and 4-core) from the same bus and
// compares them against a queue-based model of the expected record stream.
// ---------------------------------------------------------------------------
module tb_ro_bus_capture;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rstb;
  logic bus_eve;
  logic bus_pol_eve;
  logic en;
  logic ovf_clr;
  logic rdy;
  logic ovf19;
  logic ovf4;

  int vectors = 0;
  int miscompares = 0;

  // Model state: one record queue, slot count and ovf per instance.
  int q0[$];
  int q1[$];
  int m_cnt[2];
  int m_smp_cnt[2];
  bit m_ovf[2];
  bit m_smp_eve;
  bit m_smp_pol;

  ro_bus_capture_if #(.N_CH(19), .CH_W(5)) if19 ();
  ro_bus_capture_if #(.N_CH(4),  .CH_W(2)) if4 ();

  ro_bus_capture #(.N_CH(19), .DEPTH(DEPTH), .CH_W(5)) u19 (
    .clk_master  (clk),
    .rstb        (rstb),
    .bus_eve     (bus_eve),
    .bus_pol_eve (bus_pol_eve),
    .en          (en),
    .ovf_clr     (ovf_clr),
    .ovf         (ovf19),
    .out_if      (if19.master)
  );

  ro_bus_capture #(.N_CH(4), .DEPTH(DEPTH), .CH_W(2)) u4 (
    .clk_master  (clk),
    .rstb        (rstb),
    .bus_eve     (bus_eve),
    .bus_pol_eve (bus_pol_eve),
    .en          (en),
    .ovf_clr     (ovf_clr),
    .ovf         (ovf4),
    .out_if      (if4.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int nbits(int k);
    return (k == 0) ? 19 : 4;
  endfunction

  function automatic int refCtz(int c);
    int v = c;
    int z = 0;
    while ((v % 2) == 0 && z < 32) begin
      v = v / 2;
      z++;
    end
    return z;
  endfunction

  function automatic int enc(int ts, int ch, bit pol);
    return ts * 64 + ch * 2 + int'(pol);
  endfunction

  function automatic int qSize(int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int qHead(int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qPush(int k, int v);
    if (k == 0) q0.push_back(v); else q1.push_back(v);
  endtask

  task automatic qPop(int k);
    int d;
    if (k == 0) d = q0.pop_front(); else d = q1.pop_front();
  endtask

  function automatic int obsValid(int k);
    return (k == 0) ? int'(if19.out_valid) : int'(if4.out_valid);
  endfunction
  function automatic int obsTs(int k);
    return (k == 0) ? int'(if19.out_ts) : int'(if4.out_ts);
  endfunction
  function automatic int obsCh(int k);
    return (k == 0) ? int'(if19.out_ch) : int'(if4.out_ch);
  endfunction
  function automatic int obsPol(int k);
    return (k == 0) ? int'(if19.out_pol) : int'(if4.out_pol);
  endfunction
  function automatic int obsOvf(int k);
    return (k == 0) ? int'(ovf19) : int'(ovf4);
  endfunction
  function automatic int obsCnt(int k);
    return (k == 0) ? int'(u19.cnt_q) : int'(u4.cnt_q);
  endfunction

  task automatic checkOutput(string tag, int observed, int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]     = 0;
      m_smp_cnt[k] = 0;
      m_ovf[k]     = 1'b0;
    end
    m_smp_eve = 1'b0;
    m_smp_pol = 1'b0;
  endtask

  // Rising edge: pop on valid&ready, push the last falling-edge sample.
  task automatic modelEdge();
    for (int k = 0; k < 2; k++) begin
      bit pop_v;
      bit push_v;
      bit drop_v;
      pop_v  = (qSize(k) > 0) && rdy;
      push_v = m_smp_eve && en && (m_smp_cnt[k] != 0);
      drop_v = 1'b0;
      if (pop_v) qPop(k);
      if (push_v) begin
        if (qSize(k) < DEPTH)
          qPush(k, enc(m_smp_cnt[k], refCtz(m_smp_cnt[k]), m_smp_pol));
        else
          drop_v = 1'b1;
      end
      if (drop_v) m_ovf[k] = 1'b1;
      else if (ovf_clr) m_ovf[k] = 1'b0;
      m_cnt[k] = (m_cnt[k] + 1) % (1 << nbits(k));
    end
  endtask

  task automatic checkAll(string phase);
    for (int k = 0; k < 2; k++) begin
      string n;
      n = $sformatf("%s.n%0d", phase, nbits(k));
      checkOutput({n, ".cnt"}, obsCnt(k), m_cnt[k]);
      checkOutput({n, ".valid"}, obsValid(k), (qSize(k) > 0) ? 1 : 0);
      if (qSize(k) > 0) begin
        checkOutput({n, ".ts"},  obsTs(k),  qHead(k) / 64);
        checkOutput({n, ".ch"},  obsCh(k),  (qHead(k) / 2) % 32);
        checkOutput({n, ".pol"}, obsPol(k), qHead(k) % 2);
      end
      checkOutput({n, ".ovf"}, obsOvf(k), int'(m_ovf[k]));
    end
  endtask

  task automatic checkZero(string phase);
    for (int k = 0; k < 2; k++) begin
      string n;
      n = $sformatf("%s.n%0d", phase, nbits(k));
      checkOutput({n, ".cnt"},   obsCnt(k),   0);
      checkOutput({n, ".valid"}, obsValid(k), 0);
      checkOutput({n, ".ts"},    obsTs(k),    0);
      checkOutput({n, ".ch"},    obsCh(k),    0);
      checkOutput({n, ".pol"},   obsPol(k),   0);
      checkOutput({n, ".ovf"},   obsOvf(k),   0);
    end
  endtask

  // Entered in the low phase; asserts reset asynchronously there, holds it
  // with bus noise, and releases it well away from a rising edge.
  task automatic applyReset(string phase, int cycles);
    rstb = 1'b0;
    modelReset();
    #1;
    checkZero({phase, ".async"});
    repeat (cycles) begin
      @(posedge clk);
      #1;
      bus_eve = 1'($urandom);
      bus_pol_eve = 1'($urandom);
      checkZero({phase, ".hold"});
      @(negedge clk);
      #1;
      bus_eve = 1'($urandom);
      bus_pol_eve = 1'($urandom);
    end
    rstb = 1'b1;
  endtask

  // One master cycle: controls for the next rising edge, bus value for the
  // following high phase, noise on the bus during the low phase.
  task automatic applyStimulus(string phase, bit eve, bit pol, bit en_v, bit rdy_v, bit clr);
    en = en_v;
    rdy = rdy_v;
    if19.out_ready = rdy_v;
    if4.out_ready = rdy_v;
    ovf_clr = clr;
    @(posedge clk);
    modelEdge();
    #1;
    checkAll(phase);
    bus_eve = eve;
    bus_pol_eve = pol;
    @(negedge clk);
    m_smp_eve = eve;
    m_smp_pol = pol;
    for (int k = 0; k < 2; k++) m_smp_cnt[k] = m_cnt[k];
    #1;
    bus_eve = 1'($urandom);
    bus_pol_eve = 1'($urandom);
  endtask

  initial begin
    rstb = 1'b0;
    bus_eve = 1'b0;
    bus_pol_eve = 1'b0;
    en = 1'b0;
    ovf_clr = 1'b0;
    rdy = 1'b0;
    if19.out_ready = 1'b0;
    if4.out_ready = 1'b0;
    modelReset();
    @(negedge clk);
    #1;

    // Reset with a toggling bus, then idle slots 1..3.
    applyReset("reset", 3);
    repeat (3) applyStimulus("idle", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Single event in slot 4 -> {ts 4, ch 2, pol 1}.
    applyStimulus("single", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (3) applyStimulus("single", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Overflow: events at 1..5 with no consumer, then clear, then a drop
    // coinciding with a clear.
    applyReset("ovf_rst", 2);
    repeat (5) applyStimulus("ovf", 1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
    repeat (2) applyStimulus("ovf", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus("ovf_clr", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus("ovf_race", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("ovf_clr2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) applyStimulus("ovf_drain", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Full FIFO with a push and a pop on the same edge.
    applyReset("fpp_rst", 2);
    repeat (5) applyStimulus("fpp_fill", 1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
    repeat (6) applyStimulus("fpp_drain", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Continuous events: the 4-core instance wraps and skips count 0.
    applyReset("wrap_rst", 2);
    repeat (20) applyStimulus("wrap", 1'b1, 1'($urandom), 1'b1, 1'b1, 1'b0);

    // Reset with three records queued and a sample pending.
    applyReset("mid_rst", 2);
    repeat (4) applyStimulus("mid_fill", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    applyReset("mid_async", 1);
    repeat (2) applyStimulus("mid_after", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("mid_after", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) applyStimulus("mid_after", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Randomized traffic.
    applyReset("rand_rst", 1);
    repeat (400) begin
      applyStimulus("rand", ($urandom_range(0, 2) != 0), 1'($urandom),
                    ($urandom_range(0, 9) != 0), 1'($urandom),
                    ($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
